// File: rtl/mux_scan_sched_if.sv
// Bus between the scan scheduler and the control plane / mux datapath.
// The master side drives enable, requests and the mux output; the slave
// side (the scheduler) drives select, grant, samples and status.
interface mux_scan_sched_if;
   logic       en;
   logic [3:0] req;
   logic       mux_y;
   logic [1:0] sel;
   logic [3:0] grant;
   logic [3:0] sample;
   logic [3:0] sample_vld;
   logic       cap_stb;
   logic       frame_done;
   logic       busy;

   modport master (
      output en, req, mux_y,
      input  sel, grant, sample, sample_vld, cap_stb, frame_done, busy
   );

   modport slave (
      input  en, req, mux_y,
      output sel, grant, sample, sample_vld, cap_stb, frame_done, busy
   );
endinterface

// File: rtl/mux_scan_sched.sv
// Round-robin scan scheduler for a 4-channel time-multiplexed sampling path.
// Each granted channel gets one settle cycle plus DWELL hold cycles; the mux
// output is captured into that channel's sample bit on the last hold cycle.
module mux_scan_sched #(
   parameter int unsigned DWELL = 4
) (
   input logic             clk,
   input logic             rst,
   mux_scan_sched_if.slave bus
);

   typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

   localparam logic [7:0] DWELL_M1 = 8'(DWELL - 1);

   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [1:0] ptr_q, ptr_d;
   logic [1:0] sel_q, sel_d;
   logic [3:0] grant_q, grant_d;
   logic [3:0] sample_q, sample_d;
   logic [3:0] vld_q, vld_d;
   logic       capStb_q, capStb_d;
   logic       frameDone_q, frameDone_d;

   logic       capture;
   logic       arbPoint;
   logic       go;
   logic [1:0] base;
   logic [1:0] cand;
   logic [1:0] pickIdx;
   logic       pickFound;

   // Round-robin pick: search from the channel after the last one served,
   // wrapping back to it last. In HOLD the channel being captured now is
   // the reference, since ptr only catches up at the capture edge.
   always_comb begin
      base      = (state_q == HOLD) ? sel_q : ptr_q;
      cand      = 2'd0;
      pickIdx   = 2'd0;
      pickFound = 1'b0;
      for (int i = 4; i >= 1; i--) begin
         cand = base + 2'(i);
         if (bus.req[cand]) begin
            pickIdx   = cand;
            pickFound = 1'b1;
         end
      end
   end

   assign capture  = (state_q == HOLD) && (cnt_q == 8'd0);
   assign arbPoint = (state_q == IDLE) || capture;
   assign go       = arbPoint && bus.en && pickFound;

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= 8'd0;
         ptr_q       <= 2'd3;
         sel_q       <= 2'd0;
         grant_q     <= 4'd0;
         sample_q    <= 4'd0;
         vld_q       <= 4'd0;
         capStb_q    <= 1'b0;
         frameDone_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         ptr_q       <= ptr_d;
         sel_q       <= sel_d;
         grant_q     <= grant_d;
         sample_q    <= sample_d;
         vld_q       <= vld_d;
         capStb_q    <= capStb_d;
         frameDone_q <= frameDone_d;
      end
   end

   // Next-state logic and dwell counter sequencing.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (go) state_d = SETTLE;
         end
         SETTLE: begin
            state_d = HOLD;
            cnt_d   = DWELL_M1;
         end
         HOLD: begin
            if (capture) state_d = go ? SETTLE : IDLE;
            else         cnt_d   = cnt_q - 8'd1;
         end
         default: state_d = IDLE;
      endcase
   end

   // Output-side next values: grant/select on a pick, capture and pulses
   // at the end of a slot. Only the captured channel's sample bit moves.
   always_comb begin
      sel_d       = sel_q;
      grant_d     = grant_q;
      sample_d    = sample_q;
      vld_d       = vld_q;
      ptr_d       = ptr_q;
      capStb_d    = 1'b0;
      frameDone_d = 1'b0;
      if (go) begin
         sel_d   = pickIdx;
         grant_d = 4'b0001 << pickIdx;
      end
      if (capture) begin
         sample_d[sel_q] = bus.mux_y;
         vld_d[sel_q]    = 1'b1;
         ptr_d           = sel_q;
         capStb_d        = 1'b1;
         if (go) begin
            frameDone_d = (pickIdx <= sel_q);
         end else begin
            grant_d     = 4'd0;
            frameDone_d = 1'b1;
         end
      end
   end

   assign bus.sel        = sel_q;
   assign bus.grant      = grant_q;
   assign bus.sample     = sample_q;
   assign bus.sample_vld = vld_q;
   assign bus.cap_stb    = capStb_q;
   assign bus.frame_done = frameDone_q;
   assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_mux_scan_sched.sv
// Directed bench for mux_scan_sched: one DWELL=4 instance for the main
// scenarios and one DWELL=1 instance for the minimum-dwell case.
module tb_mux_scan_sched;

   logic       clk = 1'b0;
   logic       rstA;
   logic       rstB;
   logic [3:0] muxDataA;
   logic [3:0] muxDataB;
   int         nChecks = 0;
   int         nFails  = 0;

   mux_scan_sched_if ifA ();
   mux_scan_sched_if ifB ();

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   // Mux models: the serial output is the pattern bit selected by sel.
   assign ifA.mux_y = muxDataA[ifA.sel];
   assign ifB.mux_y = muxDataB[ifB.sel];

   mux_scan_sched #(.DWELL(4)) dutA (
      .clk (clk),
      .rst (rstA),
      .bus (ifA)
   );

   mux_scan_sched #(.DWELL(1)) dutB (
      .clk (clk),
      .rst (rstB),
      .bus (ifB)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulusA(input logic r, input logic e, input logic [3:0] q);
      rstA   = r;
      ifA.en = e;
      ifA.req = q;
   endtask

   task automatic applyStimulusB(input logic r, input logic e, input logic [3:0] q);
      rstB   = r;
      ifB.en = e;
      ifB.req = q;
   endtask

   // Reset held 3 cycles with requests pending, then first grant to ch0.
   task automatic test_reset();
      logic [16:0] got;
      muxDataA = 4'b1010;
      applyStimulusA(1'b1, 1'b1, 4'hF);
      for (int i = 0; i < 3; i++) begin
         step();
         got = {ifA.sel, ifA.grant, ifA.cap_stb, ifA.frame_done, ifA.busy,
                ifA.sample, ifA.sample_vld};
         nChecks++;
         if (got !== 17'd0) begin
            nFails++;
            $display("[TB] FAIL reset cycle=%0d outputs got %b want all zero", i, got);
         end
      end
      applyStimulusA(1'b0, 1'b1, 4'hF);
      step();
      got = {ifA.sel, ifA.grant, ifA.cap_stb, ifA.frame_done, ifA.busy,
             ifA.sample, ifA.sample_vld};
      nChecks++;
      if (got !== {2'd0, 4'b0001, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0}) begin
         nFails++;
         $display("[TB] FAIL firstGrant {sel,grant,cap,fd,busy,sample,vld} got %b want %b",
                  got, {2'd0, 4'b0001, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0});
      end
   endtask

   // Continues from the first grant: full 4-channel frame with pattern 1010.
   task automatic test_full_scan();
      logic [16:0] got, exp;
      logic [1:0]  ch;
      logic [3:0]  mask;
      for (int k = 0; k <= 20; k++) begin
         if (k > 0) step();
         ch   = (k < 20) ? 2'(k / 5) : 2'd0;
         mask = 4'((1 << (k / 5)) - 1);
         exp  = {ch, 4'b0001 << ch, (k > 0 && k % 5 == 0), (k == 20), 1'b1,
                 4'b1010 & mask, mask};
         got  = {ifA.sel, ifA.grant, ifA.cap_stb, ifA.frame_done, ifA.busy,
                 ifA.sample, ifA.sample_vld};
         nChecks++;
         if (got !== exp) begin
            nFails++;
            $display("[TB] FAIL fullScan k=%0d {sel,grant,cap,fd,busy,sample,vld} got %b want %b",
                     k, got, exp);
         end
      end
   endtask

   // Only channels 0 and 2 request; they alternate and 1/3 never appear.
   task automatic test_sparse();
      logic [16:0] got, exp;
      logic [1:0]  expSel;
      logic [3:0]  expVld;
      muxDataA = 4'b1111;
      applyStimulusA(1'b1, 1'b1, 4'b0101);
      step();
      applyStimulusA(1'b0, 1'b1, 4'b0101);
      step();
      for (int j = 0; j <= 20; j++) begin
         if (j > 0) step();
         expSel = ((j / 5) % 2 == 1) ? 2'd2 : 2'd0;
         expVld = (j < 5) ? 4'b0000 : (j < 10) ? 4'b0001 : 4'b0101;
         exp = {expSel, 4'b0001 << expSel, (j > 0 && j % 5 == 0),
                (j > 0 && j % 10 == 0), 1'b1, expVld, expVld};
         got = {ifA.sel, ifA.grant, ifA.cap_stb, ifA.frame_done, ifA.busy,
                ifA.sample, ifA.sample_vld};
         nChecks++;
         if (got !== exp) begin
            nFails++;
            $display("[TB] FAIL sparse j=%0d {sel,grant,cap,fd,busy,sample,vld} got %b want %b",
                     j, got, exp);
         end
      end
   endtask

   // Request and enable dropped mid-hold: the slot still completes.
   task automatic test_non_preemption();
      logic [16:0] got, exp;
      muxDataA = 4'b0010;
      applyStimulusA(1'b1, 1'b1, 4'b0010);
      step();
      applyStimulusA(1'b0, 1'b1, 4'b0010);
      step();
      for (int j = 0; j <= 6; j++) begin
         if (j > 0) step();
         if (j == 2) applyStimulusA(1'b0, 1'b0, 4'b0000);
         if (j <= 4)
            exp = {2'd1, 4'b0010, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000};
         else
            exp = {2'd1, 4'b0000, (j == 5), (j == 5), 1'b0, 4'b0010, 4'b0010};
         got = {ifA.sel, ifA.grant, ifA.cap_stb, ifA.frame_done, ifA.busy,
                ifA.sample, ifA.sample_vld};
         nChecks++;
         if (got !== exp) begin
            nFails++;
            $display("[TB] FAIL nonPreempt j=%0d {sel,grant,cap,fd,busy,sample,vld} got %b want %b",
                     j, got, exp);
         end
      end
   endtask

   // Reset during the third hold cycle of ch2, then restart at ch0.
   task automatic test_reset_mid();
      logic [16:0] got, exp;
      logic [1:0]  ch;
      logic [3:0]  mask;
      muxDataA = 4'b1111;
      applyStimulusA(1'b1, 1'b1, 4'hF);
      step();
      applyStimulusA(1'b0, 1'b1, 4'hF);
      step();
      for (int j = 0; j <= 15; j++) begin
         if (j > 0) step();
         if (j <= 13) begin
            ch   = 2'(j / 5);
            mask = 4'((1 << (j / 5)) - 1);
            exp  = {ch, 4'b0001 << ch, (j > 0 && j % 5 == 0), 1'b0, 1'b1, mask, mask};
         end else if (j == 14) begin
            exp = 17'd0;
         end else begin
            exp = {2'd0, 4'b0001, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0};
         end
         got = {ifA.sel, ifA.grant, ifA.cap_stb, ifA.frame_done, ifA.busy,
                ifA.sample, ifA.sample_vld};
         nChecks++;
         if (got !== exp) begin
            nFails++;
            $display("[TB] FAIL resetMid j=%0d {sel,grant,cap,fd,busy,sample,vld} got %b want %b",
                     j, got, exp);
         end
         if (j == 13) applyStimulusA(1'b1, 1'b1, 4'hF);
         if (j == 14) applyStimulusA(1'b0, 1'b1, 4'hF);
      end
   endtask

   // DWELL=1 with a single requester: 2-cycle slots, no gap, ch3 tracks mux_y.
   task automatic test_dwell1();
      logic [16:0] got, exp;
      logic [7:0]  pat;
      logic        lastBit;
      pat     = 8'b1011_0010;
      lastBit = 1'b0;
      rstA    = 1'b1;
      muxDataB = 4'b0000;
      applyStimulusB(1'b1, 1'b1, 4'b1000);
      step();
      applyStimulusB(1'b0, 1'b1, 4'b1000);
      step();
      for (int j = 0; j <= 15; j++) begin
         if (j > 0) step();
         exp = {2'd3, 4'b1000, (j > 0 && j % 2 == 0), (j > 0 && j % 2 == 0), 1'b1,
                {lastBit, 3'b000}, (j >= 2) ? 4'b1000 : 4'b0000};
         got = {ifB.sel, ifB.grant, ifB.cap_stb, ifB.frame_done, ifB.busy,
                ifB.sample, ifB.sample_vld};
         nChecks++;
         if (got !== exp) begin
            nFails++;
            $display("[TB] FAIL dwell1 j=%0d {sel,grant,cap,fd,busy,sample,vld} got %b want %b",
                     j, got, exp);
         end
         if (j % 2 == 1) begin
            muxDataB[3] = pat[j / 2];
            lastBit     = pat[j / 2];
         end
      end
   endtask

   // Scenario sequence and summary.
   initial begin
      muxDataA = 4'b0000;
      muxDataB = 4'b0000;
      applyStimulusA(1'b1, 1'b0, 4'h0);
      applyStimulusB(1'b1, 1'b0, 4'h0);
      test_reset();
      test_full_scan();
      test_sparse();
      test_non_preemption();
      test_reset_mid();
      test_dwell1();
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule

// File: doc/mux_scan_sched.md
# mux_scan_sched

Round-robin scan scheduler for the 4-channel time-multiplexed sampling path (4:1 bit mux with one-hot channel decode). It replaces the free-running 2-bit select counter. It drives the mux select lines and the one-hot grant only for channels that are requesting. It holds each channel for a programmable dwell, then captures the mux output into a per-channel sample register. Sits between the VIO/ILA control plane and the mux/decoder datapath.

## Interface

- DWELL, 4: cycles the mux output is held per slot before capture; legal 1..255.
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  scan enable, sampled only at arbitration points.
- req  in  4  per-channel scan request, sampled only at arbitration points.
- mux_y  in  1  serial output of the 4:1 mux, sampled only on the capture edge.
- sel  out  2  mux select {S1,S0}; registered.
- grant  out  4  one-hot decode of sel while a slot is active, else 0; registered.
- sample  out  4  captured bit per channel.
- sample_vld  out  4  sticky per-channel "captured at least once" flag; cleared only by rst.
- cap_stb  out  1  one-cycle pulse, cycle after a capture.
- frame_done  out  1  one-cycle pulse marking the end of a round-robin pass.
- busy  out  1  high in SETTLE and HOLD.

## Operation

- Reset values: sel=0, grant=0, sample=0, sample_vld=0, cap_stb=0, frame_done=0, busy=0.
- Internal reset values: state=IDLE, last-served pointer ptr=3, dwell counter=0.
- States:
  - IDLE: grant=0; sel holds its last value.
  - SETTLE: one cycle with sel/grant driven, allowing mux propagation.
  - HOLD: DWELL cycles.
- Arbitration point: IDLE every cycle; HOLD on its last cycle.
- Next-channel pick: first set bit of req searched in order ptr+1, ptr+2, ptr+3, ptr (mod 4). Channels with req=0 are skipped.
- IDLE -> SETTLE when en && |req. sel <= picked index, grant <= one-hot(picked).
- SETTLE -> HOLD unconditionally. Counter loads DWELL-1.
- HOLD decrements the counter. On the cycle where counter==0:
  - sample[sel] <= mux_y, sample_vld[sel] <= 1, ptr <= sel, cap_stb pulses next cycle.
  - If en && |req: go to SETTLE with the newly picked channel. This may be the same channel if it is the only requester.
  - Otherwise go to IDLE with grant <= 0.
- frame_done pulses together with cap_stb in two cases:
  - the next picked index ≤ captured index (wrap), or
  - no next channel is picked (return to IDLE).
- Slots are non-preemptive. Changes to req or en during SETTLE/HOLD have no effect until the arbitration point.
- Only sample[sel] changes on a capture; other channels keep their values.

## Timing

- Request seen in IDLE at edge t: sel/grant valid and busy=1 from t+1 (SETTLE).
- HOLD runs t+2 .. t+1+DWELL.
- Capture on the edge ending cycle t+1+DWELL. sample and sample_vld are visible and cap_stb=1 in cycle t+2+DWELL.
- Back-to-back slots: each slot is DWELL+1 cycles, with no IDLE gap.
  - A full 4-channel frame is 4·(DWELL+1) cycles.
  - A new grant is visible in the same cycle as the previous slot's cap_stb.
- rst asserted in any state: all outputs and internal state take reset values at the next edge. An in-flight capture is discarded. After release, scanning restarts at channel 0.
- DWELL=1: HOLD lasts one cycle; slot = 2 cycles.
- Single requester: the same channel is re-granted each slot. frame_done pulses on every capture.

## Test plan

- Reset: hold rst 3 cycles with req=4'hF, en=1 -> all outputs 0 during reset. First grant=4'b0001 appears 1 cycle after rst release.
- Full scan, DWELL=4: req=4'hF, en=1, mux_y driven from N=4'b1010 via sel.
  - grant steps 0001, 0010, 0100, 1000, each held 5 cycles.
  - sample=4'b1010 and sample_vld=4'hF after 20 cycles.
  - frame_done pulses once, with ch3's cap_stb.
- Sparse requests: req=4'b0101 -> sel alternates 00, 10; channels 1/3 are never granted; sample_vld=4'b0101. frame_done follows each ch2 capture.
- Non-preemption: drop req[1] and en mid-HOLD of ch1 -> grant stays 0010 until the capture. Then IDLE with grant=0 and busy=0; sample[1] is updated.
- Reset mid-operation: assert rst during the 3rd HOLD cycle of ch2 -> next cycle everything is 0 and sample[2] is not written. After release, ch0 is granted first.
- DWELL=1, single requester req=4'b1000: grant stays 1000 with no gap. cap_stb and frame_done pulse every 2 cycles; sample[3] tracks mux_y.
